cdc_xfer_arbiter: RTL and testbench
===================================

Name: cdc_xfer_arbiter

Overview:
Source-domain controller that shares one multi-bit clock-domain-crossing channel among NUM_REQ requesters.
- Round-robin arbitration picks one requester at a time.
- The granted word is captured into a held data register, then a toggle request is launched to the destination domain.
- The block waits for the destination's toggle acknowledge, brought in through an internal synchronizer, then reports done or timeout per requester.
- It sits in front of the clk1→clk2 synchronizer datapath and gives the benchmarks a realistic sequenced CDC path for uncertainty and latency constraints.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
DATA_W, 8, width of each transferred word.
SYNC_STAGES, 2, flops in the ack synchronizer chain (≥2).
TIMEOUT, 64, WAIT_ACK cycles before error; 0 disables timeout.

Ports:
clk  in  1  single source-domain clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  NUM_REQ  per-requester request; hold until req_done/req_err.
req_data  in  NUM_REQ*DATA_W  requester i word at [i*DATA_W +: DATA_W].
req_done  out  NUM_REQ  one-cycle pulse, transfer acknowledged.
req_err  out  NUM_REQ  one-cycle pulse, transfer timed out.
grant_id  out  $clog2(NUM_REQ)  index of current/last granted requester.
busy  out  1  high in any state other than IDLE.
xfer_data  out  DATA_W  held word toward destination domain (registered).
xfer_toggle  out  1  request toggle toward destination domain (registered).
ack_toggle_async  in  1  destination ack toggle, asynchronous to clk.

Behaviour:
- Decided: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset values:
  - state IDLE; all outputs 0, including xfer_toggle, xfer_data, grant_id.
  - Sync chain 0, timer 0, RR pointer 0, so requester 0 has highest priority first.
- States: IDLE, LAUNCH, WAIT_ACK, DONE, ERR, DRAIN.
- IDLE:
  - If any req_valid, grant the first set bit searching from the RR pointer upward with wrap.
  - On that edge: xfer_data ← granted word, grant_id ← index, go to LAUNCH.
- LAUNCH:
  - One setup cycle; xfer_data is already stable.
  - Next edge: xfer_toggle inverts, timer ← 0, go to WAIT_ACK.
- WAIT_ACK:
  - If ack_sync == xfer_toggle, go to DONE. The ack match takes priority over timeout in the same cycle.
  - Else, if TIMEOUT≠0 and timer == TIMEOUT-1, go to ERR.
  - Else timer increments.
- DONE: req_done[grant_id]=1 for this cycle only; RR pointer ← grant_id+1 (mod NUM_REQ); go to IDLE.
- ERR:
  - req_err[grant_id]=1 for one cycle; RR pointer advances as in DONE.
  - Go to DRAIN.
- DRAIN:
  - Wait, with no timeout, until ack_sync == xfer_toggle, then go to IDLE with no done pulse.
  - busy stays high; no new grant is issued.
- ack_sync is the last flop of the SYNC_STAGES chain sampling ack_toggle_async.
- xfer_data changes only on a grant edge and is constant from the LAUNCH edge until the next grant; xfer_toggle never changes in the same cycle as xfer_data.
- Deasserting req_valid after grant does not abort; the transfer completes and reports to that index. New or other requests wait in IDLE.
- Loopback latency (ack_toggle_async tied to xfer_toggle): req_done pulses SYNC_STAGES+2 cycles after the LAUNCH edge. Back-to-back period is SYNC_STAGES+4 cycles.
- req_done and req_err are decoded from registered state and grant_id only, so they are glitch-free and never both high.
- Reset mid-transfer: immediate return to reset values. The destination side must be reset together, because the toggle phase is lost.
- Target size: ~200 lines RTL.

Test Plan:
- Loopback, SYNC_STAGES=2, req_valid=4'b0001, req_data[7:0]=8'hA5 → xfer_data=8'hA5 after grant; xfer_toggle 0→1 one cycle later; req_done[0] pulses 4 cycles after the LAUNCH edge; busy low next cycle.
- Loopback, req_valid=4'b1111 held, words 8'h10/8'h11/8'h12/8'h13 → grants in order 0,1,2,3,0, each spaced 6 cycles; xfer_toggle alternates 1,0,1,0; each req_done index matches its word.
- ack_toggle_async stuck 0, TIMEOUT=8 → req_err[grant_id] pulses after 8 WAIT_ACK cycles; busy stays high in DRAIN; raising ack to 1 later → IDLE with no req_done.
- TIMEOUT=0, ack delayed 500 cycles → no req_err; req_done arrives SYNC_STAGES+1 cycles after the ack edge.
- rst_n low during WAIT_ACK → all outputs 0 asynchronously; after release with req_valid=4'b0100, requester 2 is granted first and RR pointer restarts from 0.
- Simultaneous: ack match in the same cycle timer reaches TIMEOUT-1 → req_done, not req_err. Drop req_valid during WAIT_ACK → transfer still completes with req_done.

Source files
------------

// File: rtl/cdc_xfer_arbiter.sv
// Round-robin arbiter sharing one toggle-handshake CDC channel among requesters.
// Launches a held word with a request toggle and waits for the synchronized ack.
module cdc_xfer_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [NUM_REQ-1:0]         req_err,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic [DATA_W-1:0]          xfer_data,
  output logic                       xfer_toggle,
  input  logic                       ack_toggle_async
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX =
    TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT_ACK, DONE, ERR, DRAIN
  } state_t;

  state_t                 state_q;
  logic [GW-1:0]          grant_id_q;
  logic [GW-1:0]          ptr_q;
  logic [DATA_W-1:0]      data_q;
  logic                   tog_q;
  logic [TW-1:0]          timer_q;
  logic [SYNC_STAGES-1:0] sync_q;

  logic [GW-1:0]          gnt_d;
  logic [GW-1:0]          ptr_d;
  logic [GW-1:0]          idx;
  logic                   found;
  logic                   ack_sync;
  logic                   ack_match;
  logic [NUM_REQ-1:0]     gnt_oh;

  assign ack_sync  = sync_q[SYNC_STAGES-1];
  assign ack_match = (ack_sync == tog_q);

  // First requester at or above the pointer, wrapping around.
  always_comb begin
    gnt_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = GW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        gnt_d = idx;
        found = 1'b1;
      end
    end
  end

  assign ptr_d = (grant_id_q == GW'(NUM_REQ - 1)) ?
                 '0 : grant_id_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      ptr_q      <= '0;
      data_q     <= '0;
      tog_q      <= 1'b0;
      timer_q    <= '0;
      sync_q     <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ack_toggle_async};
      unique case (state_q)
        IDLE: begin
          if (found) begin
            data_q     <= req_data[gnt_d*DATA_W +: DATA_W];
            grant_id_q <= gnt_d;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH: begin
          tog_q   <= ~tog_q;
          timer_q <= '0;
          state_q <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (ack_match) begin
            state_q <= DONE;
          end else if (TIMEOUT != 0 && timer_q == TMAX) begin
            state_q <= ERR;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        DONE: begin
          ptr_q   <= ptr_d;
          state_q <= IDLE;
        end
        ERR: begin
          ptr_q   <= ptr_d;
          state_q <= DRAIN;
        end
        DRAIN: begin
          if (ack_match) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_oh      = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_q;
  assign req_done    = (state_q == DONE) ? gnt_oh : '0;
  assign req_err     = (state_q == ERR)  ? gnt_oh : '0;
  assign busy        = (state_q != IDLE);
  assign grant_id    = grant_id_q;
  assign xfer_data   = data_q;
  assign xfer_toggle = tog_q;

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Randomized bench for cdc_xfer_arbiter against a transaction-level model.
// Two instances: TIMEOUT=8 for most scenarios, TIMEOUT=0 for the long wait.
module tb_cdc_xfer_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  rv, rv0;
  logic [31:0] rd, rd0;
  logic        loop, man, ack0;

  logic [3:0]  done8, err8, done0, err0;
  logic [1:0]  gid8, gid0;
  logic        busy8, busy0, tog8, tog0;
  logic [7:0]  xd8, xd0;
  wire         ack8 = loop ? tog8 : man;

  int vec = 0;
  int miss = 0;
  int cyc = 0;
  int ptr_m = 0;
  logic tog_m = 1'b0;

  always #5 clk = ~clk;

  cdc_xfer_arbiter #(
    .NUM_REQ(4), .DATA_W(8), .SYNC_STAGES(2), .TIMEOUT(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv), .req_data(rd),
    .req_done(done8), .req_err(err8),
    .grant_id(gid8), .busy(busy8),
    .xfer_data(xd8), .xfer_toggle(tog8),
    .ack_toggle_async(ack8)
  );

  cdc_xfer_arbiter #(
    .NUM_REQ(4), .DATA_W(8), .SYNC_STAGES(2), .TIMEOUT(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv0), .req_data(rd0),
    .req_done(done0), .req_err(err0),
    .grant_id(gid0), .busy(busy0),
    .xfer_data(xd0), .xfer_toggle(tog0),
    .ack_toggle_async(ack0)
  );

  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Round-robin rule: first set bit at or above p, wrapping.
  function automatic int pick(input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++)
      if (m[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] oh(input int i);
    logic [3:0] r;
    r = 4'b0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic do_reset;
    rst_n = 1'b0;
    rv = 4'b0; rv0 = 4'b0;
    loop = 1'b1; man = 1'b0; ack0 = 1'b0;
    repeat (2) step;
    rst_n = 1'b1;
    ptr_m = 0;
    tog_m = 1'b0;
    step;
  endtask

  task automatic test_reset;
    rd = 32'hDEADBEEF; rd0 = 32'h0;
    rv = 4'b0; rv0 = 4'b0;
    loop = 1'b1; man = 1'b0; ack0 = 1'b0;
    rst_n = 1'b0;
    repeat (2) step;
    vec++;
    if ({busy8, tog8, gid8, xd8, done8, err8} !== 18'h0) begin
      miss++;
      $display("FAIL reset_hold got %h want 0",
               {busy8, tog8, gid8, xd8, done8, err8});
    end
    rst_n = 1'b1;
    step;
    vec++;
    if ({busy0, tog0, gid0, xd0, done0, err0} !== 18'h0) begin
      miss++;
      $display("FAIL reset_rel0 got %h want 0",
               {busy0, tog0, gid0, xd0, done0, err0});
    end
    vec++;
    if ({busy8, tog8, gid8, xd8} !== 12'h0) begin
      miss++;
      $display("FAIL reset_rel got %h want 0",
               {busy8, tog8, gid8, xd8});
    end
  endtask

  task automatic test_single;
    int n;
    do_reset;
    rd = {$urandom} & 32'hFFFF_FF00 | 32'hA5;
    rv = 4'b0001;
    step;
    vec++;
    if (gid8 !== 2'd0 || xd8 !== 8'hA5 || busy8 !== 1'b1) begin
      miss++;
      $display("FAIL single_grant got g%0d d%h b%b want g0 dA5 b1",
               gid8, xd8, busy8);
    end
    vec++;
    if (tog8 !== 1'b0) begin
      miss++;
      $display("FAIL single_tog0 got %b want 0", tog8);
    end
    step;
    vec++;
    if (tog8 !== 1'b1 || xd8 !== 8'hA5) begin
      miss++;
      $display("FAIL single_tog1 got t%b d%h want t1 dA5", tog8, xd8);
    end
    n = 1;
    while (done8 === 4'b0 && n < 20) begin
      step;
      n++;
    end
    vec++;
    if (n !== 4 || done8 !== 4'b0001 || err8 !== 4'b0) begin
      miss++;
      $display("FAIL single_done got n%0d d%b e%b want n4 d0001 e0000",
               n, done8, err8);
    end
    rv = 4'b0;
    step;
    vec++;
    if (busy8 !== 1'b0 || done8 !== 4'b0) begin
      miss++;
      $display("FAIL single_idle got b%b d%b want b0 d0", busy8, done8);
    end
  endtask

  task automatic test_round_robin;
    int n, e, g_cyc;
    do_reset;
    rv = 4'b1111;
    rd = {8'h13, 8'h12, 8'h11, 8'h10};
    step;
    g_cyc = cyc;
    for (int t = 0; t < 5; t++) begin
      e = pick(rv, ptr_m);
      vec++;
      if (gid8 !== 2'(e) || xd8 !== rd[e*8 +: 8]) begin
        miss++;
        $display("FAIL rr_grant%0d got g%0d d%h want g%0d d%h",
                 t, gid8, xd8, e, rd[e*8 +: 8]);
      end
      step;
      tog_m = ~tog_m;
      vec++;
      if (tog8 !== tog_m) begin
        miss++;
        $display("FAIL rr_tog%0d got %b want %b", t, tog8, tog_m);
      end
      n = 1;
      while (done8 === 4'b0 && n < 20) begin
        step;
        n++;
      end
      vec++;
      if (n !== 4 || done8 !== oh(e)) begin
        miss++;
        $display("FAIL rr_done%0d got n%0d d%b want n4 d%b",
                 t, n, done8, oh(e));
      end
      ptr_m = (e + 1) % 4;
      if (t == 4) rv = 4'b0;
      step;
      if (t < 4) begin
        n = 0;
        while (busy8 !== 1'b1 && n < 20) begin
          step;
          n++;
        end
        vec++;
        if (cyc - g_cyc !== 6) begin
          miss++;
          $display("FAIL rr_period%0d got %0d want 6", t, cyc - g_cyc);
        end
        g_cyc = cyc;
      end
    end
    vec++;
    if (busy8 !== 1'b0) begin
      miss++;
      $display("FAIL rr_end got %b want 0", busy8);
    end
  endtask

  task automatic test_random;
    int n, e;
    logic [3:0] m;
    logic [31:0] w;
    do_reset;
    for (int t = 0; t < 40; t++) begin
      m = 4'($urandom_range(1, 15));
      w = $urandom;
      rv = m;
      rd = w;
      step;
      e = pick(m, ptr_m);
      vec++;
      if (gid8 !== 2'(e) || xd8 !== w[e*8 +: 8] || busy8 !== 1'b1) begin
        miss++;
        $display("FAIL rand_grant%0d got g%0d d%h want g%0d d%h",
                 t, gid8, xd8, e, w[e*8 +: 8]);
      end
      if ($urandom_range(0, 1) == 1) rv = 4'b0;
      rd = $urandom;
      step;
      tog_m = ~tog_m;
      n = 1;
      while (done8 === 4'b0 && n < 20) begin
        step;
        n++;
      end
      vec++;
      if (n !== 4 || done8 !== oh(e) || tog8 !== tog_m ||
          xd8 !== w[e*8 +: 8]) begin
        miss++;
        $display("FAIL rand_done%0d got n%0d d%b t%b x%h want n4 d%b t%b x%h",
                 t, n, done8, tog8, xd8, oh(e), tog_m, w[e*8 +: 8]);
      end
      ptr_m = (e + 1) % 4;
      rv = 4'b0;
      repeat ($urandom_range(1, 3)) step;
      vec++;
      if (busy8 !== 1'b0) begin
        miss++;
        $display("FAIL rand_idle%0d got %b want 0", t, busy8);
      end
    end
  endtask

  task automatic test_timeout;
    int n;
    logic bad;
    do_reset;
    loop = 1'b0;
    man = 1'b0;
    rv = 4'b0010;
    step;
    vec++;
    if (gid8 !== 2'd1) begin
      miss++;
      $display("FAIL to_grant got %0d want 1", gid8);
    end
    n = 0;
    bad = 1'b0;
    while (err8 === 4'b0 && n < 40) begin
      step;
      n++;
      bad |= |done8;
    end
    vec++;
    if (n !== 9 || err8 !== 4'b0010 || done8 !== 4'b0 || bad) begin
      miss++;
      $display("FAIL to_err got n%0d e%b d%b want n9 e0010 d0000",
               n, err8, done8);
    end
    rv = 4'b0;
    bad = 1'b0;
    repeat (10) begin
      step;
      bad |= (busy8 !== 1'b1) || (|done8) || (|err8);
    end
    vec++;
    if (bad) begin
      miss++;
      $display("FAIL to_drain got bad=%b want 0", bad);
    end
    man = 1'b1;
    n = 0;
    bad = 1'b0;
    while (busy8 === 1'b1 && n < 20) begin
      step;
      n++;
      bad |= |done8;
    end
    vec++;
    if (n !== 3 || busy8 !== 1'b0 || bad) begin
      miss++;
      $display("FAIL to_release got n%0d b%b done_seen%b want n3 b0 0",
               n, busy8, bad);
    end
    loop = 1'b1;
    tog_m = 1'b1;
    ptr_m = 2;
    rv = 4'b0011;
    step;
    vec++;
    if (gid8 !== 2'(pick(4'b0011, ptr_m))) begin
      miss++;
      $display("FAIL to_ptr got %0d want %0d", gid8, pick(4'b0011, ptr_m));
    end
    n = 0;
    while (done8 === 4'b0 && n < 20) begin
      step;
      n++;
    end
    vec++;
    if (done8 !== 4'b0001) begin
      miss++;
      $display("FAIL to_after got %b want 0001", done8);
    end
    rv = 4'b0;
    step;
  endtask

  task automatic test_simultaneous;
    int n;
    for (int d = 6; d <= 7; d++) begin
      do_reset;
      loop = 1'b0;
      man = 1'b0;
      rv = 4'b1000;
      step;
      n = 0;
      while (done8 === 4'b0 && err8 === 4'b0 && n < 30) begin
        step;
        n++;
        if (n == 2) rv = 4'b0;
        if (n == d) man = 1'b1;
      end
      vec++;
      if (d == 6 && (n !== 9 || done8 !== 4'b1000 || err8 !== 4'b0)) begin
        miss++;
        $display("FAIL sim_done got n%0d d%b e%b want n9 d1000 e0000",
                 n, done8, err8);
      end
      if (d == 7 && (n !== 9 || err8 !== 4'b1000 || done8 !== 4'b0)) begin
        miss++;
        $display("FAIL sim_late got n%0d d%b e%b want n9 d0000 e1000",
                 n, done8, err8);
      end
      n = 0;
      while (busy8 === 1'b1 && n < 20) begin
        step;
        n++;
      end
    end
  endtask

  task automatic test_no_timeout;
    int n;
    logic bad;
    logic [31:0] w;
    do_reset;
    w = $urandom;
    rd0 = w;
    rv0 = 4'b0001;
    step;
    vec++;
    if (gid0 !== 2'd0 || xd0 !== w[7:0]) begin
      miss++;
      $display("FAIL nt_grant got g%0d d%h want g0 d%h", gid0, xd0, w[7:0]);
    end
    bad = 1'b0;
    repeat (500) begin
      step;
      bad |= (|err0) || (|done0) || (busy0 !== 1'b1);
    end
    vec++;
    if (bad) begin
      miss++;
      $display("FAIL nt_wait got bad=%b want 0", bad);
    end
    ack0 = 1'b1;
    n = 0;
    while (done0 === 4'b0 && n < 20) begin
      step;
      n++;
    end
    vec++;
    if (n !== 3 || done0 !== 4'b0001 || err0 !== 4'b0) begin
      miss++;
      $display("FAIL nt_done got n%0d d%b e%b want n3 d0001 e0000",
               n, done0, err0);
    end
    rv0 = 4'b0;
    step;
    vec++;
    if (busy0 !== 1'b0) begin
      miss++;
      $display("FAIL nt_idle got %b want 0", busy0);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    do_reset;
    rd = $urandom;
    rv = 4'b0001;
    step;
    n = 0;
    while (done8 === 4'b0 && n < 20) begin
      step;
      n++;
    end
    rv = 4'b0;
    step;
    loop = 1'b0;
    man = 1'b1;
    rv = 4'b0010;
    repeat (4) step;
    #3;
    rst_n = 1'b0;
    loop = 1'b1;
    rv = 4'b0;
    #1;
    vec++;
    if ({busy8, tog8, gid8, xd8, done8, err8} !== 18'h0) begin
      miss++;
      $display("FAIL mid_reset got %h want 0",
               {busy8, tog8, gid8, xd8, done8, err8});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rv = 4'b0101;
    step;
    vec++;
    if (gid8 !== 2'd0) begin
      miss++;
      $display("FAIL mid_ptr got %0d want 0", gid8);
    end
    n = 0;
    while (done8 === 4'b0 && n < 20) begin
      step;
      n++;
    end
    rv = 4'b0;
    step;
    rv = 4'b0100;
    step;
    vec++;
    if (gid8 !== 2'd2) begin
      miss++;
      $display("FAIL mid_g2 got %0d want 2", gid8);
    end
    n = 0;
    while (done8 === 4'b0 && n < 20) begin
      step;
      n++;
    end
    vec++;
    if (done8 !== 4'b0100) begin
      miss++;
      $display("FAIL mid_done got %b want 0100", done8);
    end
    rv = 4'b0;
    step;
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_random;
    test_timeout;
    test_simultaneous;
    test_no_timeout;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
